// File: rtl/seq_mini_alu_if.sv
// Operand/result handshake bundle for seq_mini_alu.
// The master side drives operands and out_ready; the slave side is the ALU.
interface seq_mini_alu_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned RES_W = 2 * WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_result;
    logic             out_flag;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_flag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_flag
    );
endinterface

// File: rtl/seq_mini_alu.sv
// Multi-cycle add/sub/mul ALU with valid/ready handshakes on both sides.
// Define SEQ_MINI_ALU_DIV_EN to add a restoring divider on op 11.
module seq_mini_alu #(
    parameter int unsigned WIDTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    seq_mini_alu_if.slave bus
);
    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned CntW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CntW-1:0]  cnt_q;
    logic [RES_W-1:0] acc_q;
    logic [RES_W-1:0] res_q;
    logic             flag_q;

    logic [WIDTH:0]   add_sum;
    logic [RES_W-1:0] sub_diff;
    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] mul_acc;
    logic [RES_W-1:0] calc_acc;

`ifdef SEQ_MINI_ALU_DIV_EN
    logic [1:0]       op_q;
    logic [WIDTH:0]   div_top;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [RES_W-1:0] div_acc;
`endif

    always_comb begin
        add_sum  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        sub_diff = {{WIDTH{1'b0}}, bus.in_a} - {{WIDTH{1'b0}}, bus.in_b};
        a_ext    = {{WIDTH{1'b0}}, a_q};
        mul_acc  = acc_q + (b_q[cnt_q] ? (a_ext << cnt_q) : '0);
`ifdef SEQ_MINI_ALU_DIV_EN
        // acc_q = {remainder, dividend/quotient}; shift one dividend bit into the remainder.
        div_top  = acc_q[RES_W-1:WIDTH-1];
        div_ge   = div_top >= {1'b0, b_q};
        div_rem  = div_ge ? WIDTH'(div_top - {1'b0, b_q}) : div_top[WIDTH-1:0];
        div_acc  = {div_rem, acc_q[WIDTH-2:0], div_ge};
        calc_acc = (op_q == OpMul) ? mul_acc : div_acc;
`else
        calc_acc = mul_acc;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
`ifdef SEQ_MINI_ALU_DIV_EN
            op_q    <= OpAdd;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.in_a;
                        b_q   <= bus.in_b;
                        cnt_q <= '0;
`ifdef SEQ_MINI_ALU_DIV_EN
                        op_q  <= bus.in_op;
`endif
                        unique case (bus.in_op)
                            OpAdd: begin
                                res_q   <= {{(WIDTH-1){1'b0}}, add_sum};
                                flag_q  <= add_sum[WIDTH];
                                state_q <= StDone;
                            end
                            OpSub: begin
                                res_q   <= sub_diff;
                                flag_q  <= bus.in_a < bus.in_b;
                                state_q <= StDone;
                            end
                            OpMul: begin
                                acc_q   <= '0;
                                state_q <= StCalc;
                            end
                            OpDiv: begin
`ifdef SEQ_MINI_ALU_DIV_EN
                                acc_q   <= {{WIDTH{1'b0}}, bus.in_a};
                                state_q <= StCalc;
`else
                                res_q   <= '0;
                                flag_q  <= 1'b1;
                                state_q <= StDone;
`endif
                            end
                            default: state_q <= StIdle;
                        endcase
                    end
                end
                StCalc: begin
                    acc_q <= calc_acc;
                    cnt_q <= cnt_q + CntW'(1);
                    // The last iteration's sum is committed straight to the output register.
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        cnt_q   <= '0;
                        res_q   <= calc_acc;
                        state_q <= StDone;
`ifdef SEQ_MINI_ALU_DIV_EN
                        flag_q  <= (op_q == OpDiv) && (b_q == '0);
`else
                        flag_q  <= 1'b0;
`endif
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.out_result = res_q;
    assign bus.out_flag   = flag_q;
endmodule

// File: tb/tb_seq_mini_alu.sv
// Directed vector table, handshake corner cases and an exhaustive sweep for seq_mini_alu.
module tb_seq_mini_alu;
    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    seq_mini_alu_if #(.WIDTH(W)) bus ();

    seq_mini_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [7:0] res;
        logic       flag;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                                  output logic [7:0] r, output logic f, output int l);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        l  = 1;
        case (op)
            2'b00: begin r = 8'(ia + ib); f = (ia + ib) > 15; end
            2'b01: begin r = 8'(ia - ib); f = ia < ib; end
            2'b10: begin r = 8'(ia * ib); f = 1'b0; l = W + 1; end
            default: begin
`ifdef SEQ_MINI_ALU_DIV_EN
                l = W + 1;
                if (ib == 0) begin r = {a, 4'hF}; f = 1'b1; end
                else begin r = 8'((ia % ib) * 16 + ia / ib); f = 1'b0; end
`else
                r = 8'h00;
                f = 1'b1;
`endif
            end
        endcase
    endfunction

    // Called #1 after an edge with the DUT idle and out_ready high.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          output logic [7:0] res, output logic f, output int lat,
                          output logic busy_ok);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.in_op    = ~op;
        lat          = 1;
        busy_ok      = 1'b1;
        while (!bus.out_valid && lat < 20) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            bus.in_a = $urandom_range(15, 0);
            bus.in_b = $urandom_range(15, 0);
            lat++;
        end
        if (bus.in_ready) busy_ok = 1'b0;
        res = bus.out_result;
        f   = bus.out_flag;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] res;
        logic [7:0] exp_r;
        logic       f;
        logic       exp_f;
        logic       busy_ok;
        int         lat;
        int         exp_l;

        n_cmp = 0;
        n_bad = 0;

        vecs.push_back('{4'd15, 4'd15, 2'b00, 8'h1E, 1'b1, 1});
        vecs.push_back('{4'd3,  4'd4,  2'b00, 8'h07, 1'b0, 1});
        vecs.push_back('{4'd3,  4'd5,  2'b01, 8'hFE, 1'b1, 1});
        vecs.push_back('{4'd9,  4'd2,  2'b01, 8'h07, 1'b0, 1});
        vecs.push_back('{4'd15, 4'd15, 2'b10, 8'hE1, 1'b0, 5});
        vecs.push_back('{4'd7,  4'd3,  2'b10, 8'h15, 1'b0, 5});
        vecs.push_back('{4'd0,  4'd9,  2'b10, 8'h00, 1'b0, 5});
`ifdef SEQ_MINI_ALU_DIV_EN
        vecs.push_back('{4'd13, 4'd4,  2'b11, 8'h13, 1'b0, 5});
        vecs.push_back('{4'd7,  4'd0,  2'b11, 8'h7F, 1'b1, 5});
`else
        vecs.push_back('{4'd13, 4'd4,  2'b11, 8'h00, 1'b1, 1});
`endif

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("in_ready during reset", 32'(bus.in_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_result", 32'(bus.out_result), 32'd0);
        chk("reset out_flag", 32'(bus.out_flag), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, res, f, lat, busy_ok);
            chk($sformatf("vec%0d result", i), 32'(res), 32'(vecs[i].res));
            chk($sformatf("vec%0d flag", i), 32'(f), 32'(vecs[i].flag));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d in_ready low while busy", i), 32'(busy_ok), 32'd1);
            chk($sformatf("vec%0d in_ready after", i), 32'(bus.in_ready), 32'd1);
        end

        // Backpressure: result must stay frozen and new requests ignored.
        bus.out_ready = 1'b0;
        bus.in_a      = 4'd1;
        bus.in_b      = 4'd1;
        bus.in_op     = 2'b00;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            bus.in_a  = 4'd9;
            bus.in_b  = 4'd6;
            bus.in_op = 2'b10;
            chk($sformatf("bp%0d out_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d out_result", k), 32'(bus.out_result), 32'h02);
            chk($sformatf("bp%0d out_flag", k), 32'(bus.out_flag), 32'd0);
            chk($sformatf("bp%0d in_ready", k), 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp result held in idle", 32'(bus.out_result), 32'h02);

        // Reset two cycles into a multiply.
        bus.in_a     = 4'd15;
        bus.in_b     = 4'd15;
        bus.in_op    = 2'b10;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre-abort in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort out_result", 32'(bus.out_result), 32'd0);
        chk("abort in_ready", 32'(bus.in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(4'd2, 4'd3, 2'b00, res, f, lat, busy_ok);
        chk("post-abort add result", 32'(res), 32'h05);
        chk("post-abort add flag", 32'(f), 32'd0);
        chk("post-abort add latency", 32'(lat), 32'd1);

        for (int op = 0; op < 4; op++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    model(4'(a), 4'(b), 2'(op), exp_r, exp_f, exp_l);
                    run_op(4'(a), 4'(b), 2'(op), res, f, lat, busy_ok);
                    chk($sformatf("sweep op%0d a%0d b%0d result", op, a, b), 32'(res), 32'(exp_r));
                    chk($sformatf("sweep op%0d a%0d b%0d flag", op, a, b), 32'(f), 32'(exp_f));
                    chk($sformatf("sweep op%0d a%0d b%0d latency", op, a, b), 32'(lat),
                        32'(exp_l));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
